cpu_run_controller: RTL and testbench

Sequencing controller for the softcore CPU: replaces the raw divided-counter CPU clock with a single-clock, clock-enable scheme. It provides debounced run/halt, single-step, speed selection and CPU reset from the board buttons. It sits between the board inputs and the `control_unit` clock-enable and reset inputs, and runs on `clk_50mhz` alongside `cpu_monitor`.

---
 rtl/cpu_ctrl_pkg.sv | 23 ++
 rtl/btn_debounce.sv | 60 ++++++
 rtl/cpu_run_controller.sv | 139 +++++++++++++
 tb/tb_cpu_run_controller.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared encodings for the CPU run controller.
// State codes, button indices and a counter-width helper.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RESET_HOLD = 2'b00,
    ST_HALT       = 2'b01,
    ST_STEP       = 2'b10,
    ST_RUN        = 2'b11
  } state_e;

  localparam int BTN_RUN   = 0;
  localparam int BTN_STEP  = 1;
  localparam int BTN_SPEED = 2;
  localparam int BTN_RST   = 3;
  localparam int NUM_BTN   = 4;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: sync, debounce and press pulse for one button.
// Active-low raw input; pulse only on an accepted 1->0 change.
module btn_debounce
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_50mhz,
  input  logic reset_n,
  input  logic btn_n,
  output logic press
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_done;

  assign w_diff = r_sync2 ^ r_stable;
  assign w_done = w_diff && (r_cnt == CNT_LAST);
  assign press  = r_press;

  // Two-flop synchronizer; idles released (high).
  always_ff @(posedge clk_50mhz) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level after it persists; pulse on press.
  always_ff @(posedge clk_50mhz) begin
    if (!reset_n) begin
      r_stable <= 1'b1;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_press <= w_done & ~r_sync2;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: run/halt/step sequencer for the softcore.
// Drives a clock enable and reset to the CPU from board buttons.
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RUN_DIV_SLOW    = 8388608,
  parameter int RUN_DIV_FAST    = 1048576,
  parameter int RESET_CYCLES    = 4
) (
  input  logic        clk_50mhz,
  input  logic        reset_n,
  input  logic [3:0]  btn_n,
  input  logic        halt_req,
  output logic        cpu_ce,
  output logic        cpu_reset,
  output logic [1:0]  state,
  output logic        fast,
  output logic [15:0] ce_count
);

  localparam int DIV_MAX =
    (RUN_DIV_SLOW > RUN_DIV_FAST) ? RUN_DIV_SLOW : RUN_DIV_FAST;
  localparam int DW = cnt_w(DIV_MAX);
  localparam int HW = cnt_w(RESET_CYCLES);
  localparam logic [DW-1:0] SLOW_LAST = DW'(RUN_DIV_SLOW - 1);
  localparam logic [DW-1:0] FAST_LAST = DW'(RUN_DIV_FAST - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);

  state_e        r_state;
  logic [HW-1:0] r_hold;
  logic [DW-1:0] r_div;
  logic          r_ce;
  logic          r_rst;
  logic          r_fast;
  logic [15:0]   r_ce_count;

  logic [NUM_BTN-1:0] w_ev;
  logic               w_fast_nx;
  logic [DW-1:0]      w_div_last;
  logic               w_div_wrap;
  logic [DW-1:0]      w_div_nx;
  logic               w_div_hit;
  logic [15:0]        w_cnt_inc;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_50mhz(clk_50mhz),
      .reset_n  (reset_n),
      .btn_n    (btn_n[gi]),
      .press    (w_ev[gi])
    );
  end

  // Divider restarts on speed change and whenever not running,
  // so every RUN entry begins from zero.
  assign w_fast_nx  = r_fast ^ w_ev[BTN_SPEED];
  assign w_div_last = w_fast_nx ? FAST_LAST : SLOW_LAST;
  assign w_div_wrap = w_ev[BTN_SPEED]
                   || (r_state != ST_RUN)
                   || (r_div >= w_div_last);
  assign w_div_nx   = w_div_wrap ? '0 : r_div + 1'b1;
  assign w_div_hit  = (w_div_nx == w_div_last);
  assign w_cnt_inc  = r_ce_count + 16'd1;

  // Sequencer FSM with registered enable, reset and counters.
  always_ff @(posedge clk_50mhz) begin
    if (!reset_n) begin
      r_state    <= ST_RESET_HOLD;
      r_hold     <= '0;
      r_div      <= '0;
      r_ce       <= 1'b0;
      r_rst      <= 1'b1;
      r_fast     <= 1'b0;
      r_ce_count <= '0;
    end else begin
      r_fast <= w_fast_nx;
      r_div  <= w_div_nx;
      r_ce   <= 1'b0;
      if (w_ev[BTN_RST]) begin
        r_state    <= ST_RESET_HOLD;
        r_hold     <= '0;
        r_rst      <= 1'b1;
        r_ce       <= 1'b1;
        r_ce_count <= '0;
      end else begin
        unique case (r_state)
          ST_RESET_HOLD: begin
            r_ce_count <= '0;
            // r_ce low only on the cycle after reset_n release.
            if (!r_ce) begin
              r_ce <= 1'b1;
            end else if (r_hold == HOLD_LAST) begin
              r_state <= ST_HALT;
              r_rst   <= 1'b0;
            end else begin
              r_hold <= r_hold + 1'b1;
              r_ce   <= 1'b1;
            end
          end
          ST_HALT: begin
            if (w_ev[BTN_RUN]) begin
              r_state <= ST_RUN;
              r_ce    <= w_div_hit;
              if (w_div_hit) r_ce_count <= w_cnt_inc;
            end else if (w_ev[BTN_STEP]) begin
              r_state    <= ST_STEP;
              r_ce       <= 1'b1;
              r_ce_count <= w_cnt_inc;
            end
          end
          ST_STEP: begin
            r_state <= ST_HALT;
          end
          ST_RUN: begin
            if (halt_req || w_ev[BTN_RUN]) begin
              r_state <= ST_HALT;
            end else begin
              r_ce <= w_div_hit;
              if (w_div_hit) r_ce_count <= w_cnt_inc;
            end
          end
          default: begin
            r_state <= ST_HALT;
          end
        endcase
      end
    end
  end

  assign cpu_ce    = r_ce;
  assign cpu_reset = r_rst;
  assign state     = r_state;
  assign fast      = r_fast;
  assign ce_count  = r_ce_count;

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb_cpu_run_controller: directed scenarios for the run controller.
// Inputs change and outputs are sampled on the falling edge.
module tb_cpu_run_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  btn_n = 4'hF;
  logic        halt_req = 1'b0;
  logic        cpu_ce;
  logic        cpu_reset;
  logic [1:0]  state;
  logic        fast;
  logic [15:0] ce_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_run_controller #(
    .DEBOUNCE_CYCLES(4),
    .RUN_DIV_SLOW   (16),
    .RUN_DIV_FAST   (4),
    .RESET_CYCLES   (4)
  ) dut (
    .clk_50mhz(clk),
    .reset_n  (reset_n),
    .btn_n    (btn_n),
    .halt_req (halt_req),
    .cpu_ce   (cpu_ce),
    .cpu_reset(cpu_reset),
    .state    (state),
    .fast     (fast),
    .ce_count (ce_count)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    btn_n = 4'hF;
    halt_req = 1'b0;
    repeat (3) tick();
    checks++;
    if (state !== 2'b00 || cpu_reset !== 1'b1 || cpu_ce !== 1'b0) begin
      failures++;
      $display("FAIL in_reset state=%b rst=%b ce=%b want 00 1 0",
               state, cpu_reset, cpu_ce);
    end
    checks++;
    if (fast !== 1'b0 || ce_count !== 16'd0) begin
      failures++;
      $display("FAIL in_reset_regs fast=%b cnt=%0d want 0 0",
               fast, ce_count);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (state !== 2'b00 || cpu_reset !== 1'b1 || cpu_ce !== 1'b1) begin
        failures++;
        $display("FAIL hold%0d state=%b rst=%b ce=%b want 00 1 1",
                 i, state, cpu_reset, cpu_ce);
      end
    end
    tick();
    checks++;
    if (state !== 2'b01 || cpu_reset !== 1'b0 || cpu_ce !== 1'b0
        || ce_count !== 16'd0) begin
      failures++;
      $display("FAIL hold_exit state=%b rst=%b ce=%b cnt=%0d want 01 0 0 0",
               state, cpu_reset, cpu_ce, ce_count);
    end
  endtask

  task automatic test_step_bounce();
    int pulses = 0;
    int first = -1;
    for (int i = 0; i < 8; i++) begin
      btn_n[1] = ((i >> 1) & 1) != 0;
      tick();
      if (cpu_ce === 1'b1) pulses++;
    end
    btn_n[1] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (cpu_ce === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
      if (i == 7) begin
        checks++;
        if (state !== 2'b10) begin
          failures++;
          $display("FAIL step_state got=%b want=10", state);
        end
      end
    end
    btn_n[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cpu_ce === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || first != 7) begin
      failures++;
      $display("FAIL step_pulses got=%0d@%0d want=1@7", pulses, first);
    end
    checks++;
    if (ce_count !== 16'd1 || state !== 2'b01) begin
      failures++;
      $display("FAIL step_after cnt=%0d state=%b want 1 01",
               ce_count, state);
    end
  endtask

  task automatic test_run_slow();
    int pulses = 0;
    int first = -1;
    int last = -1;
    int perr = 0;
    btn_n[0] = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (cpu_ce === 1'b1) pulses++;
    end
    checks++;
    if (state !== 2'b11 || pulses != 0) begin
      failures++;
      $display("FAIL run_entry state=%b pulses=%0d want 11 0",
               state, pulses);
    end
    btn_n[0] = 1'b1;
    for (int i = 8; i <= 167; i++) begin
      tick();
      if (cpu_ce === 1'b1) begin
        if (first < 0) first = i;
        else if (i - last != 16) perr++;
        last = i;
        pulses++;
      end
    end
    checks++;
    if (first != 22 || pulses != 10 || perr != 0) begin
      failures++;
      $display("FAIL run_slow first=%0d n=%0d perr=%0d want 22 10 0",
               first, pulses, perr);
    end
    checks++;
    if (ce_count !== 16'd11 || state !== 2'b11 || fast !== 1'b0) begin
      failures++;
      $display("FAIL run_slow_regs cnt=%0d state=%b fast=%b want 11 11 0",
               ce_count, state, fast);
    end
  endtask

  task automatic test_speed();
    int pulses = 0;
    int first = -1;
    int last = -1;
    int perr = 0;
    btn_n[2] = 1'b0;
    for (int i = 1; i <= 26; i++) begin
      tick();
      if (cpu_ce === 1'b1) begin
        if (first < 0) first = i;
        else if (i - last != 4) perr++;
        last = i;
        pulses++;
      end
      if (i == 6 || i == 7) begin
        checks++;
        if (fast !== (i == 7)) begin
          failures++;
          $display("FAIL fast_t%0d got=%b want=%0d", i, fast, i == 7);
        end
      end
    end
    btn_n[2] = 1'b1;
    checks++;
    if (first != 10 || pulses != 5 || perr != 0) begin
      failures++;
      $display("FAIL run_fast first=%0d n=%0d perr=%0d want 10 5 0",
               first, pulses, perr);
    end
    checks++;
    if (ce_count !== 16'd16) begin
      failures++;
      $display("FAIL fast_cnt got=%0d want=16", ce_count);
    end
  endtask

  task automatic test_halt_collide();
    int pulses = 0;
    btn_n[0] = 1'b0;
    for (int i = 1; i <= 6; i++) tick();
    halt_req = 1'b1;
    tick();
    checks++;
    if (state !== 2'b01 || cpu_ce !== 1'b0 || ce_count !== 16'd17) begin
      failures++;
      $display("FAIL halt_collide state=%b ce=%b cnt=%0d want 01 0 17",
               state, cpu_ce, ce_count);
    end
    btn_n[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cpu_ce === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || state !== 2'b01) begin
      failures++;
      $display("FAIL halt_quiet pulses=%0d state=%b want 0 01",
               pulses, state);
    end
    btn_n[1] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 7) begin
        checks++;
        if (state !== 2'b10 || cpu_ce !== 1'b1) begin
          failures++;
          $display("FAIL step_halt_req state=%b ce=%b want 10 1",
                   state, cpu_ce);
        end
      end
    end
    checks++;
    if (state !== 2'b01 || cpu_ce !== 1'b0 || ce_count !== 16'd18) begin
      failures++;
      $display("FAIL step_halt_after state=%b ce=%b cnt=%0d want 01 0 18",
               state, cpu_ce, ce_count);
    end
    btn_n[1] = 1'b1;
    halt_req = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset_btn();
    btn_n[0] = 1'b0;
    for (int i = 1; i <= 7; i++) tick();
    checks++;
    if (state !== 2'b11) begin
      failures++;
      $display("FAIL rerun_state got=%b want=11", state);
    end
    btn_n[0] = 1'b1;
    for (int i = 8; i <= 15; i++) tick();
    checks++;
    if (ce_count !== 16'd20) begin
      failures++;
      $display("FAIL rerun_cnt got=%0d want=20", ce_count);
    end
    btn_n[0] = 1'b0;
    btn_n[3] = 1'b0;
    for (int r = 1; r <= 6; r++) tick();
    checks++;
    if (ce_count !== 16'd21 || state !== 2'b11) begin
      failures++;
      $display("FAIL pre_rst cnt=%0d state=%b want 21 11",
               ce_count, state);
    end
    for (int r = 7; r <= 10; r++) begin
      tick();
      checks++;
      if (state !== 2'b00 || cpu_reset !== 1'b1 || cpu_ce !== 1'b1
          || ce_count !== 16'd0) begin
        failures++;
        $display("FAIL btn_rst_r%0d st=%b rst=%b ce=%b cnt=%0d want 00 1 1 0",
                 r, state, cpu_reset, cpu_ce, ce_count);
      end
    end
    tick();
    checks++;
    if (state !== 2'b01 || cpu_reset !== 1'b0 || cpu_ce !== 1'b0) begin
      failures++;
      $display("FAIL btn_rst_exit st=%b rst=%b ce=%b want 01 0 0",
               state, cpu_reset, cpu_ce);
    end
    btn_n[0] = 1'b1;
    btn_n[3] = 1'b1;
    repeat (10) tick();
    checks++;
    if (state !== 2'b01 || ce_count !== 16'd0) begin
      failures++;
      $display("FAIL btn_rst_idle st=%b cnt=%0d want 01 0",
               state, ce_count);
    end
  endtask

  task automatic test_reset_mid_debounce();
    btn_n[1] = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    checks++;
    if (state !== 2'b00 || cpu_reset !== 1'b1 || cpu_ce !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst state=%b rst=%b ce=%b want 00 1 0",
               state, cpu_reset, cpu_ce);
    end
    reset_n = 1'b1;
    for (int i = 6; i <= 13; i++) begin
      tick();
      if (i == 9) begin
        checks++;
        if (state !== 2'b00 || cpu_ce !== 1'b1) begin
          failures++;
          $display("FAIL mid_hold state=%b ce=%b want 00 1", state, cpu_ce);
        end
      end
      if (i == 11) begin
        checks++;
        if (state !== 2'b01 || cpu_ce !== 1'b0) begin
          failures++;
          $display("FAIL early_event state=%b ce=%b want 01 0",
                   state, cpu_ce);
        end
      end
      if (i == 12) begin
        checks++;
        if (state !== 2'b10 || cpu_ce !== 1'b1 || ce_count !== 16'd1) begin
          failures++;
          $display("FAIL late_step st=%b ce=%b cnt=%0d want 10 1 1",
                   state, cpu_ce, ce_count);
        end
      end
    end
    checks++;
    if (state !== 2'b01 || cpu_ce !== 1'b0) begin
      failures++;
      $display("FAIL late_step_end state=%b ce=%b want 01 0",
               state, cpu_ce);
    end
    btn_n[1] = 1'b1;
    repeat (8) tick();
  endtask

  initial begin
    test_reset();
    test_step_bounce();
    test_run_slow();
    test_speed();
    test_halt_collide();
    test_reset_btn();
    test_reset_mid_debounce();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
